// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the execute-stage multiply/divide unit:
// op_type encodings and the multiply/divide FSM state type.
package cpu_defs;

    localparam int MD_OP_W = 3;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DONE    = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_div_core.sv
// Unsigned radix-2 restoring divider datapath: one quotient bit per step.
// Next-step quotient/remainder are exposed so the owner can commit on the last step.
module md_div_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_last,
    output logic [DATA_W-1:0] o_quo_next,
    output logic [DATA_W-1:0] o_rem_next
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvs;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W:0]   w_shifted;
    logic [DATA_W:0]   w_diff;

    // A zero divisor never borrows, which naturally yields all-ones quotient and rem = dividend.
    assign w_shifted  = {r_rem, r_quo[DATA_W-1]};
    assign w_diff     = w_shifted - {1'b0, r_dvs};
    assign o_rem_next = w_diff[DATA_W] ? w_shifted[DATA_W-1:0] : w_diff[DATA_W-1:0];
    assign o_quo_next = {r_quo[DATA_W-2:0], ~w_diff[DATA_W]};
    assign o_last     = (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
            r_cnt <= '0;
        end else if (i_abort) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_rem <= o_rem_next;
            r_quo <= o_quo_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Execute-stage multiply/divide engine owning HI/LO. Multiplies and MTHI/MTLO commit in one
// cycle; divides run DATA_W iterations in md_div_core while busy stalls the front of the pipe.
module exe_muldiv_unit
    import cpu_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_type,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_t           r_state;
    md_state_t           w_state_next;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_neg_q;
    logic                r_neg_r;
    md_op_t              w_op;
    logic                w_is_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_abs_a;
    logic [DATA_W-1:0]   w_abs_b;
    logic [2*DATA_W-1:0] w_ext_a;
    logic [2*DATA_W-1:0] w_ext_b;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_div_start;
    logic                w_div_step;
    logic                w_div_abort;
    logic                w_div_last;
    logic [DATA_W-1:0]   w_quo_next;
    logic [DATA_W-1:0]   w_rem_next;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;
    logic                w_busy;
    logic                w_hi_we;
    logic                w_lo_we;
    logic [DATA_W-1:0]   w_hi_d;
    logic [DATA_W-1:0]   w_lo_d;

    assign w_op        = md_op_t'(op_type);
    assign w_is_signed = (w_op == MD_DIV);
    assign w_a_neg     = w_is_signed & src_a[DATA_W-1];
    assign w_b_neg     = w_is_signed & src_b[DATA_W-1];
    assign w_abs_a     = w_a_neg ? (~src_a + 1'b1) : src_a;
    assign w_abs_b     = w_b_neg ? (~src_b + 1'b1) : src_b;

    // Sign- or zero-extending to 2*DATA_W lets one unsigned multiply serve both MULT and MULTU.
    assign w_ext_a = (w_op == MD_MULT) ? {{DATA_W{src_a[DATA_W-1]}}, src_a} : {{DATA_W{1'b0}}, src_a};
    assign w_ext_b = (w_op == MD_MULT) ? {{DATA_W{src_b[DATA_W-1]}}, src_b} : {{DATA_W{1'b0}}, src_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_quo_fix = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_fix = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

    md_div_core #(.DATA_W(DATA_W)) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_step     (w_div_step),
        .i_abort    (w_div_abort),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_last     (w_div_last),
        .o_quo_next (w_quo_next),
        .o_rem_next (w_rem_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_div_start  = 1'b0;
        w_div_step   = 1'b0;
        w_div_abort  = 1'b0;
        w_hi_we      = 1'b0;
        w_lo_we      = 1'b0;
        w_hi_d       = r_hi;
        w_lo_d       = r_lo;
        case (r_state)
            IDLE: begin
                if (op_valid && !cancel) begin
                    case (w_op)
                        MD_MULT, MD_MULTU: begin
                            w_hi_we = 1'b1;
                            w_lo_we = 1'b1;
                            w_hi_d  = w_prod[2*DATA_W-1:DATA_W];
                            w_lo_d  = w_prod[DATA_W-1:0];
                        end
                        MD_DIV, MD_DIVU: begin
                            w_busy       = 1'b1;
                            w_div_start  = 1'b1;
                            w_state_next = DIV_RUN;
                        end
                        MD_MTHI: begin
                            w_hi_we = 1'b1;
                            w_hi_d  = src_a;
                        end
                        MD_MTLO: begin
                            w_lo_we = 1'b1;
                            w_lo_d  = src_a;
                        end
                        default: ;
                    endcase
                end
            end
            DIV_RUN: begin
                w_busy = 1'b1;
                if (cancel) begin
                    w_div_abort  = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_div_step = 1'b1;
                    if (w_div_last) begin
                        w_hi_we      = 1'b1;
                        w_lo_we      = 1'b1;
                        w_hi_d       = w_rem_fix;
                        w_lo_d       = w_quo_fix;
                        w_state_next = DONE;
                    end
                end
            end
            // The divide instruction is still in exe here, so its op_valid must not restart it.
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            if (w_hi_we) r_hi <= w_hi_d;
            if (w_lo_we) r_lo <= w_lo_d;
            if (w_div_start) begin
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end
        end
    end

    assign busy = w_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
